inst_mem_loadable: RTL and testbench

- Parametrised, run-time loadable instruction memory for the 16-bit multi-cycle CPU. It replaces the fixed initial-block program store.
- After reset it clears itself to a fill word, one word per cycle.
- It accepts a program stream through a valid/ready load port, then serves instruction fetches with a registered read of 1-cycle latency.
- It sits between the boot/testbench program source and the datapath fetch stage.

---
 rtl/inst_mem_loadable.sv | 117 +++++++++++
 tb/tb_inst_mem_loadable.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loadable.sv
// Run-time loadable instruction memory: self-clears to FILL_WORD after reset,
// accepts a program over a valid/ready port, then serves 1-cycle registered fetches.
module inst_mem_loadable #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 16'hE540
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_inst,
  output logic                  busy
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH:0]     load_count_q;
  logic                    load_done_q;
  logic                    fetch_valid_q;
  logic [DATA_WIDTH-1:0]   fetch_inst_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    xfer;
  logic                    fetch_accept;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // One pointer serves both the clear sweep and the load write address.
  always_comb begin
    xfer         = (state_q == LOAD) && load_valid;
    fetch_accept = (state_q == IDLE) && fetch_req && !load_start;
    mem_we       = !rst && ((state_q == CLEAR) || xfer);
    mem_wdata    = (state_q == CLEAR) ? FILL_WORD : load_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      ptr_q         <= '0;
      load_count_q  <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= '0;
    end else begin
      load_done_q   <= 1'b0;
      fetch_valid_q <= fetch_accept;
      if (fetch_accept) begin
        fetch_inst_q <= mem[fetch_addr];
      end
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == LAST_ADDR) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (load_start) begin
            state_q      <= LOAD;
            ptr_q        <= '0;
            load_count_q <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr_q        <= ptr_q + ADDR_WIDTH'(1);
            load_count_q <= load_count_q + (ADDR_WIDTH + 1)'(1);
            // The top address ends the load so the pointer never wraps onto word 0.
            if (load_last || (ptr_q == LAST_ADDR)) begin
              state_q     <= IDLE;
              load_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign fetch_ready = (state_q == IDLE) && !load_start;
  assign busy        = (state_q != IDLE);
  assign load_done   = load_done_q;
  assign load_count  = load_count_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_inst  = fetch_inst_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable at DEPTH=16: clear, fetch, load, stall,
// forced end on the top address, load_start/fetch priority and reset abort.
module tb_inst_mem_loadable;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          load_valid;
  logic          load_last;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic [AW:0]   load_count;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_inst;
  logic          busy;

  int checks = 0;
  int errors = 0;

  inst_mem_loadable #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FILL_WORD (16'hE540)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic sendWord(input logic [DW-1:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetchCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
    checkOutput("fetch_valid", 32'(fetch_valid), 32'd1);
    checkOutput("fetch_inst", 32'(fetch_inst), 32'(expected));
  endtask

  // Counts busy cycles after the reset edge; the clear must take exactly 16.
  task automatic waitClear(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    checkOutput(tag, 32'(n), 32'd16);
  endtask

  initial begin
    int accepted;
    rst        = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;

    tick();
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    checkOutput("rst_fetch_inst", 32'(fetch_inst), 32'd0);
    checkOutput("rst_load_count", 32'(load_count), 32'd0);
    checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    waitClear("clear_cycles");

    // Back-to-back fetches after clear: one result per cycle.
    fetch_req  = 1'b1;
    fetch_addr = 4'd0;
    #1;
    checkOutput("idle_fetch_ready", 32'(fetch_ready), 32'd1);
    tick();
    checkOutput("b2b0_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b0_inst", 32'(fetch_inst), 32'hE540);
    fetch_addr = 4'd7;
    tick();
    checkOutput("b2b7_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b7_inst", 32'(fetch_inst), 32'hE540);
    fetch_addr = 4'd15;
    tick();
    checkOutput("b2b15_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b15_inst", 32'(fetch_inst), 32'hE540);
    fetch_req = 1'b0;
    tick();
    checkOutput("idle_no_valid", 32'(fetch_valid), 32'd0);
    checkOutput("idle_inst_hold", 32'(fetch_inst), 32'hE540);

    // Four-word load with a five-cycle stall between words 2 and 3.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("load_ready", 32'(load_ready), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_count0", 32'(load_count), 32'd0);
    sendWord(16'hE100, 1'b0);
    sendWord(16'h01F4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      fetch_req  = (i == 2);
      fetch_addr = 4'd0;
      #1;
      checkOutput("stall_fetch_ready", 32'(fetch_ready), 32'd0);
      tick();
      checkOutput("stall_no_valid", 32'(fetch_valid), 32'd0);
      checkOutput("stall_load_ready", 32'(load_ready), 32'd1);
      checkOutput("stall_count", 32'(load_count), 32'd2);
    end
    fetch_req = 1'b0;
    sendWord(16'h8202, 1'b0);
    checkOutput("pre_last_done", 32'(load_done), 32'd0);
    sendWord(16'h11FE, 1'b1);
    checkOutput("load4_done", 32'(load_done), 32'd1);
    checkOutput("load4_count", 32'(load_count), 32'd4);
    checkOutput("load4_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("load4_done_pulse", 32'(load_done), 32'd0);
    fetchCheck(4'd0, 16'hE100);
    fetchCheck(4'd1, 16'h01F4);
    fetchCheck(4'd2, 16'h8202);
    fetchCheck(4'd3, 16'h11FE);
    fetchCheck(4'd4, 16'hE540);

    // Twenty words without load_last: the load must stop after address 15.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hA000 + 16'(i);
      #1;
      checkOutput("stream_ready", 32'(load_ready), (i < 16) ? 32'd1 : 32'd0);
      if (load_ready) accepted++;
      tick();
      if (i == 15) begin
        checkOutput("stream_done", 32'(load_done), 32'd1);
        checkOutput("stream_count", 32'(load_count), 32'd16);
      end
    end
    load_valid = 1'b0;
    checkOutput("stream_accepted", 32'(accepted), 32'd16);
    checkOutput("stream_count_hold", 32'(load_count), 32'd16);
    fetchCheck(4'd0, 16'hA000);
    fetchCheck(4'd15, 16'hA00F);

    // load_start beats a simultaneous fetch request.
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 4'd3;
    #1;
    checkOutput("prio_fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    checkOutput("prio_no_valid", 32'(fetch_valid), 32'd0);
    checkOutput("prio_in_load", 32'(load_ready), 32'd1);

    // Reset after two words aborts the load and reruns the clear.
    sendWord(16'hB001, 1'b0);
    sendWord(16'hB002, 1'b0);
    checkOutput("abort_count2", 32'(load_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_no_done", 32'(load_done), 32'd0);
    checkOutput("abort_count", 32'(load_count), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    waitClear("reclear_cycles");
    checkOutput("reclear_no_done", 32'(load_done), 32'd0);
    fetchCheck(4'd0, 16'hE540);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
